// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, general and link write ports,
// write-to-read bypass, optional zero register, pending scoreboard and a soft-clear sweep.
module regfile_sb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit ZERO_REG  = 1'b0,
    parameter bit BYPASS    = 1'b1,
    parameter int LINK_ADDR = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_ADDR);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_t;

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic wr_ok, link_ok, rsv_ok;
    logic byp_wr_a, byp_link_a, byp_wr_b, byp_link_b;

    // Effective enables: everything is frozen while the sweep owns the array.
    assign wr_ok   = wr_en   && !clr_busy && !(ZERO_REG && wr_addr == '0);
    assign link_ok = link_en && !clr_busy && !(ZERO_REG && LINK_A == '0);
    assign rsv_ok  = rsv_en  && !clr_busy && !(ZERO_REG && rsv_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = SWEEP;
            SWEEP:   if (idx == '1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state)
            SWEEP: clr_busy = 1'b1;
            DONE: begin
                clr_busy = 1'b1;
                clr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (state == SWEEP) begin
            idx <= idx + ADDR_W'(1);
        end else begin
            idx <= '0;
        end
    end

    // Link is applied before the general port so wr_data wins on a shared address;
    // the reservation comes last so it wins over a same-cycle write's pending clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend <= '0;
        end else if (state == SWEEP) begin
            mem[idx]  <= '0;
            pend[idx] <= 1'b0;
        end else begin
            if (link_ok) begin
                mem[LINK_A]  <= link_data;
                pend[LINK_A] <= 1'b0;
            end
            if (wr_ok) begin
                mem[wr_addr]  <= wr_data;
                pend[wr_addr] <= 1'b0;
            end
            if (rsv_ok) pend[rsv_addr] <= 1'b1;
        end
    end

    always_comb begin
        byp_wr_a   = BYPASS && wr_ok && (wr_addr == rd_addr_a);
        byp_link_a = BYPASS && link_ok && (LINK_A == rd_addr_a);
        rd_data_a  = mem[rd_addr_a];
        busy_a     = pend[rd_addr_a];
        if (byp_wr_a) rd_data_a = wr_data;
        else if (byp_link_a) rd_data_a = link_data;
        if (byp_wr_a || byp_link_a) busy_a = 1'b0;
        if (ZERO_REG && rd_addr_a == '0) begin
            rd_data_a = '0;
            busy_a    = 1'b0;
        end
    end

    always_comb begin
        byp_wr_b   = BYPASS && wr_ok && (wr_addr == rd_addr_b);
        byp_link_b = BYPASS && link_ok && (LINK_A == rd_addr_b);
        rd_data_b  = mem[rd_addr_b];
        busy_b     = pend[rd_addr_b];
        if (byp_wr_b) rd_data_b = wr_data;
        else if (byp_link_b) rd_data_b = link_data;
        if (byp_wr_b || byp_link_b) busy_b = 1'b0;
        if (ZERO_REG && rd_addr_b == '0) begin
            rd_data_b = '0;
            busy_b    = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default instance plus a ZERO_REG=1 instance on shared inputs.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic [31:0] wr_data, link_data;
    logic        wr_en, link_en, rsv_en, clr_req;

    logic [31:0] rd_data_a, rd_data_b, z_rd_data_a, z_rd_data_b;
    logic        busy_a, busy_b, clr_busy, clr_done;
    logic        z_busy_a, z_busy_b, z_clr_busy, z_clr_done;

    int checks;
    int fails;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .busy_a(busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_sb #(.ZERO_REG(1'b1)) dutz (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(z_rd_data_a), .busy_a(z_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(z_rd_data_b), .busy_b(z_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(z_clr_busy), .clr_done(z_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle_inputs;
        wr_en = 1'b0; link_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
        wr_addr = '0; wr_data = '0; link_data = '0; rsv_addr = '0;
    endtask

    task test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            checks++;
            if ({rd_data_a, rd_data_b, busy_a, busy_b} !== 66'd0) begin
                fails++;
                $display("[TB] FAIL reset_read[%0d]: got a=%h b=%h busy=%b%b, expected zeros", i, rd_data_a, rd_data_b, busy_a, busy_b);
            end
        end
        checks++;
        if ({clr_busy, clr_done, z_clr_busy, z_clr_done} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_clr: got %b, expected 0000", {clr_busy, clr_done, z_clr_busy, z_clr_done});
        end
    endtask

    task test_bypass;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr_a = 5'd5; rd_addr_b = 5'd4;
        #1;
        checks++;
        if (rd_data_a !== 32'hDEADBEEF || busy_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bypass_same_cycle: got %h/%b, expected deadbeef/0", rd_data_a, busy_a);
        end
        checks++;
        if (rd_data_b !== 32'h0) begin
            fails++;
            $display("[TB] FAIL bypass_other_addr: got %h, expected 00000000", rd_data_b);
        end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 32'hDEADBEEF) begin
            fails++;
            $display("[TB] FAIL bypass_next_cycle: got %h, expected deadbeef", rd_data_a);
        end
    endtask

    task test_link;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h11111111;
        link_en = 1'b1; link_data = 32'h22222222;
        rd_addr_a = 5'd31;
        #1;
        checks++;
        if (rd_data_a !== 32'h11111111) begin
            fails++;
            $display("[TB] FAIL link_collide_bypass: got %h, expected 11111111", rd_data_a);
        end
        tick();
        wr_en = 1'b0; link_en = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 32'h11111111) begin
            fails++;
            $display("[TB] FAIL link_collide_stored: got %h, expected 11111111", rd_data_a);
        end
        link_en = 1'b1; link_data = 32'h22222222;
        #1;
        checks++;
        if (rd_data_a !== 32'h22222222) begin
            fails++;
            $display("[TB] FAIL link_bypass: got %h, expected 22222222", rd_data_a);
        end
        tick();
        link_en = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 32'h22222222) begin
            fails++;
            $display("[TB] FAIL link_alone: got %h, expected 22222222", rd_data_a);
        end
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000000A;
        link_en = 1'b1; link_data = 32'h33333333;
        tick();
        idle_inputs();
        rd_addr_a = 5'd10; rd_addr_b = 5'd31;
        #1;
        checks++;
        if (rd_data_a !== 32'h0000000A || rd_data_b !== 32'h33333333) begin
            fails++;
            $display("[TB] FAIL link_dual_write: got %h/%h, expected 0000000a/33333333", rd_data_a, rd_data_b);
        end
    endtask

    task test_back_to_back;
        for (int i = 12; i <= 14; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hC0DE0000 | 32'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_addr_a = 5'd12; rd_addr_b = 5'd14;
        #1;
        checks++;
        if (rd_data_a !== 32'hC0DE000C || rd_data_b !== 32'hC0DE000E) begin
            fails++;
            $display("[TB] FAIL b2b_12_14: got %h/%h, expected c0de000c/c0de000e", rd_data_a, rd_data_b);
        end
        rd_addr_a = 5'd13;
        #1;
        checks++;
        if (rd_data_a !== 32'hC0DE000D) begin
            fails++;
            $display("[TB] FAIL b2b_13: got %h, expected c0de000d", rd_data_a);
        end
    endtask

    task test_scoreboard;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        rsv_en = 1'b0;
        rd_addr_b = 5'd7; rd_addr_a = 5'd6;
        #1;
        checks++;
        if (busy_b !== 1'b1 || busy_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rsv_set: got busy_b=%b busy_a=%b, expected 1/0", busy_b, busy_a);
        end
        rsv_en = 1'b1; rsv_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5;
        #1;
        checks++;
        if (rd_data_b !== 32'h5 || busy_b !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rsv_wr_bypass: got %h/%b, expected 00000005/0", rd_data_b, busy_b);
        end
        tick();
        rsv_en = 1'b0; wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_b !== 32'h5 || busy_b !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rsv_wr_collide: got %h/%b, expected 00000005/1", rd_data_b, busy_b);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h9;
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_b !== 32'h9 || busy_b !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wr_clears_pend: got %h/%b, expected 00000009/0", rd_data_b, busy_b);
        end
        rsv_en = 1'b1; rsv_addr = 5'd31;
        tick();
        rsv_en = 1'b0;
        rd_addr_a = 5'd31;
        #1;
        checks++;
        if (busy_a !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rsv_link_entry: got %b, expected 1", busy_a);
        end
        link_en = 1'b1; link_data = 32'h44;
        tick();
        link_en = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || rd_data_a !== 32'h44) begin
            fails++;
            $display("[TB] FAIL link_clears_pend: got %h/%b, expected 00000044/0", rd_data_a, busy_a);
        end
    endtask

    task test_soft_clear;
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA5000000 | 32'(i);
            rsv_en = (i == 31); rsv_addr = 5'd3;
            tick();
        end
        idle_inputs();
        rd_addr_a = 5'd3; rd_addr_b = 5'd31;
        #1;
        checks++;
        if (busy_a !== 1'b1 || rd_data_b !== 32'hA500001F) begin
            fails++;
            $display("[TB] FAIL fill: got busy3=%b e31=%h, expected 1/a500001f", busy_a, rd_data_b);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            wr_en = (n == 5); wr_addr = 5'd2; wr_data = 32'h00000BAD;
            rsv_en = (n == 5); rsv_addr = 5'd1;
            link_en = (n == 6); link_data = 32'h77;
            clr_req = (n == 10) || (n == 33);
            rd_addr_a = 5'd2; rd_addr_b = 5'd31;
            #1;
            if (n == 5 || n == 6) begin
                checks++;
                if (rd_data_a !== 32'h0 || rd_data_b !== 32'hA500001F) begin
                    fails++;
                    $display("[TB] FAIL sweep_mix[%0d]: got %h/%h, expected 00000000/a500001f", n, rd_data_a, rd_data_b);
                end
            end
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_at = n;
            end
            if (!clr_busy) break;
            tick();
        end
        idle_inputs();
        checks++;
        if (busy_cnt !== 33 || done_cnt !== 1 || done_at !== 33) begin
            fails++;
            $display("[TB] FAIL sweep_timing: got busy=%0d done=%0d at=%0d, expected 33/1/33", busy_cnt, done_cnt, done_at);
        end
        tick();
        checks++;
        if (clr_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL done_ignores_req: got clr_busy=%b, expected 0", clr_busy);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(i);
            #1;
            checks++;
            if ({rd_data_a, busy_a, busy_b} !== 34'd0) begin
                fails++;
                $display("[TB] FAIL swept[%0d]: got %h busy=%b%b, expected 0", i, rd_data_a, busy_a, busy_b);
            end
        end
    endtask

    task test_reset_mid_sweep;
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h20;
        tick();
        wr_addr = 5'd25; wr_data = 32'h25;
        rsv_en = 1'b1; rsv_addr = 5'd22;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int n = 1; n < 10; n++) tick();
        checks++;
        if (clr_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_sweep_busy: got %b, expected 1", clr_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_abort: got busy=%b done=%b, expected 0/0", clr_busy, clr_done);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(i);
            #1;
            checks++;
            if ({rd_data_a, busy_b} !== 33'd0) begin
                fails++;
                $display("[TB] FAIL reset_sweep[%0d]: got %h busy=%b, expected 0", i, rd_data_a, busy_b);
            end
        end
    endtask

    task test_zero_reg;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFF;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        #1;
        checks++;
        if (rd_data_a !== 32'hFF || z_rd_data_a !== 32'h0 || z_busy_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zero_bypass: got %h/%h/%b, expected 000000ff/00000000/0", rd_data_a, z_rd_data_a, z_busy_a);
        end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 32'hFF || z_rd_data_a !== 32'h0) begin
            fails++;
            $display("[TB] FAIL zero_write: got %h/%h, expected 000000ff/00000000", rd_data_a, z_rd_data_a);
        end
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rsv_en = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b1 || z_busy_a !== 1'b0 || z_busy_b !== 1'b0 || z_rd_data_b !== 32'h0) begin
            fails++;
            $display("[TB] FAIL zero_rsv: got %b/%b/%b/%h, expected 1/0/0/00000000", busy_a, z_busy_a, z_busy_b, z_rd_data_b);
        end
        link_en = 1'b1; link_data = 32'h66;
        tick();
        link_en = 1'b0;
        rd_addr_b = 5'd31;
        #1;
        checks++;
        if (z_rd_data_b !== 32'h66 || rd_data_b !== 32'h66) begin
            fails++;
            $display("[TB] FAIL zero_link: got %h/%h, expected 00000066/00000066", z_rd_data_b, rd_data_b);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        idle_inputs();
        test_reset();
        test_bypass();
        test_link();
        test_back_to_back();
        test_scoreboard();
        test_soft_clear();
        test_reset_mid_sweep();
        test_zero_reg();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
